// File: rtl/ram_bist_ctrl_if.sv
// ============================================================================
// Module      : ram_bist_ctrl_if
// Description : Start/status and RAM-side bus of the RAM BIST controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_bist_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  logic          start;
  logic [AW-1:0] add;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          en;
  logic          w;
  logic          r;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [6:0]    err_cnt;

  modport master (
    input  start, rdata,
    output add, wdata, en, w, r, busy, done, pass, fail_addr, err_cnt
  );

  modport slave (
    output start, rdata,
    input  add, wdata, en, w, r, busy, done, pass, fail_addr, err_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
// ============================================================================
// Module      : ram_bist_ctrl
// Description : Write-then-read RAM BIST with one-cycle read latency.
//               RAM_BIST_INV_PASS_EN adds a second pass with inverted data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bist_ctrl #(
  parameter int DW = 16,
  parameter int AW = 6
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ram_bist_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] c_LAST    = '1;
  localparam logic [6:0]    c_ERR_MAX = 7'd127;

  function automatic logic [DW-1:0] f_pat(input logic [AW-1:0] a, input logic inv);
    logic [15:0] p;
    p = {a[5:0], ~a[5:0], a[3:0]};
    return DW'(p) ^ {DW{inv}};
  endfunction

  state_t        r_state;
  logic [AW-1:0] r_add;
  logic [DW-1:0] r_wdata;
  logic          r_en;
  logic          r_w;
  logic          r_r;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [AW-1:0] r_fail_addr;
  logic [6:0]    r_err_cnt;
  logic          r_cmp_v;
  logic [AW-1:0] r_cmp_a;
  logic          w_pass1;
  logic          w_cmp_inv;
  logic          w_mismatch;

`ifdef RAM_BIST_INV_PASS_EN
  logic r_pass1;
  logic r_cmp_inv;
  assign w_pass1   = r_pass1;
  assign w_cmp_inv = r_cmp_inv;
`else
  assign w_pass1   = 1'b0;
  assign w_cmp_inv = 1'b0;
`endif

  // Read data returns one cycle after the strobe, so compare against the delayed address
  assign w_mismatch = r_cmp_v && (bus.rdata != f_pat(r_cmp_a, w_cmp_inv));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_add       <= '0;
      r_wdata     <= '0;
      r_en        <= 1'b0;
      r_w         <= 1'b0;
      r_r         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
      r_err_cnt   <= '0;
      r_cmp_v     <= 1'b0;
      r_cmp_a     <= '0;
`ifdef RAM_BIST_INV_PASS_EN
      r_pass1     <= 1'b0;
      r_cmp_inv   <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_cmp_v <= r_r;
      r_cmp_a <= r_add;
`ifdef RAM_BIST_INV_PASS_EN
      r_cmp_inv <= r_pass1;
`endif
      // err_cnt saturates and never wraps, so zero marks the first mismatch
      if (w_mismatch) begin
        if (r_err_cnt != c_ERR_MAX) r_err_cnt <= r_err_cnt + 7'd1;
        if (r_err_cnt == '0)        r_fail_addr <= r_cmp_a;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state     <= S_WR;
            r_add       <= '0;
            r_wdata     <= f_pat('0, 1'b0);
            r_en        <= 1'b1;
            r_w         <= 1'b1;
            r_busy      <= 1'b1;
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
            r_pass      <= 1'b0;
`ifdef RAM_BIST_INV_PASS_EN
            r_pass1     <= 1'b0;
`endif
          end
        end
        S_WR: begin
          if (r_add == c_LAST) begin
            r_state <= S_RD;
            r_add   <= '0;
            r_wdata <= '0;
            r_w     <= 1'b0;
            r_r     <= 1'b1;
          end else begin
            r_add   <= r_add + 1'b1;
            r_wdata <= f_pat(r_add + 1'b1, w_pass1);
          end
        end
        S_RD: begin
          if (r_add == c_LAST) begin
            r_state <= S_FLUSH;
            r_add   <= '0;
            r_en    <= 1'b0;
            r_r     <= 1'b0;
          end else begin
            r_add <= r_add + 1'b1;
          end
        end
        S_FLUSH: begin
`ifdef RAM_BIST_INV_PASS_EN
          if (!r_pass1) begin
            r_pass1 <= 1'b1;
            r_state <= S_WR;
            r_add   <= '0;
            r_wdata <= f_pat('0, 1'b1);
            r_en    <= 1'b1;
            r_w     <= 1'b1;
          end else begin
            r_state <= S_DONE;
          end
`else
          r_state <= S_DONE;
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_pass  <= (r_err_cnt == '0);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.add       = r_add;
  assign bus.wdata     = r_wdata;
  assign bus.en        = r_en;
  assign bus.w         = r_w;
  assign bus.r         = r_r;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.fail_addr = r_fail_addr;
  assign bus.err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
// ============================================================================
// Module      : tb_ram_bist_ctrl
// Description : Self-checking bench for ram_bist_ctrl with a faultable RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_bist_ctrl;

`ifdef RAM_BIST_INV_PASS_EN
  localparam int NP  = 2;
  localparam int LAT = 259;
`else
  localparam int NP  = 1;
  localparam int LAT = 130;
`endif
  localparam int DONE_T   = NP * 129 + 1;
  localparam int ZERO_ERR = (NP == 2) ? 127 : 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_bist_ctrl_if #(.DW(16), .AW(6)) bus ();

  ram_bist_ctrl #(.DW(16), .AW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Faultable RAM: stuck bits are applied when a word is stored
  logic [15:0] mem [64];
  logic [15:0] sa0 [64];
  logic [15:0] sa1 [64];
  logic [15:0] rd_q      = 16'h0;
  bit          zero_mode = 1'b0;

  always @(posedge clk) begin
    if (bus.en && bus.w) mem[bus.add] <= (bus.wdata | sa1[bus.add]) & ~sa0[bus.add];
    if (bus.en && bus.r) rd_q <= mem[bus.add];
  end
  assign bus.rdata = zero_mode ? 16'h0 : rd_q;

  function automatic logic [15:0] pat(input int p, input int a);
    logic [15:0] v;
    v = 16'(((a & 63) << 10) | (((~a) & 63) << 4) | (a & 15));
    return (p != 0) ? ~v : v;
  endfunction

  // Reference model: cycle index t since start accepted, plus fault map per pass/address
  bit bad [2][64];
  bit active = 1'b0;
  int t      = 0;
  int h_err  = 0;
  int h_fa   = 0;
  bit h_pass = 1'b0;
  int m_e, m_fa;
  bit chk_en = 1'b0;

  task automatic build_bad();
    logic [15:0] rd;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 64; k++) begin
        rd = zero_mode ? 16'h0 : ((pat(p, k) | sa1[k]) & ~sa0[k]);
        bad[p][k] = (p < NP) && (rd != pat(p, k));
      end
  endtask

  // Read of (p,k) is issued at t=p*129+64+k and its result is visible from t=p*129+66+k
  task automatic calc(input int tt, output int e, output int fa);
    e = 0; fa = 0;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 64; k++)
        if (bad[p][k] && (p * 129 + 66 + k <= tt)) begin
          if (e == 0) fa = k;
          if (e < 127) e++;
        end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      active = 1'b0; h_err = 0; h_fa = 0; h_pass = 1'b0;
    end else if (!active || t == DONE_T) begin
      if (active) begin
        calc(t, m_e, m_fa);
        h_err = m_e; h_fa = m_fa; h_pass = (m_e == 0); active = 1'b0;
      end
      if (bus.start) begin
        active = 1'b1; t = 0; build_bad();
      end
    end else begin
      t = t + 1;
    end
  end

  always @(negedge clk) begin
    logic        e_en, e_w, e_r, e_busy, e_done, e_pass;
    logic [5:0]  e_add, e_fa;
    logic [15:0] e_wd;
    logic [6:0]  e_err;
    int          ce, cfa, p, o;
    if (chk_en) begin
      e_en = 0; e_w = 0; e_r = 0; e_busy = 0; e_done = 0; e_add = 0; e_wd = 0;
      e_err = 7'(h_err); e_fa = 6'(h_fa); e_pass = h_pass;
      if (active) begin
        e_busy = (t <= NP * 129);
        e_done = (t == DONE_T);
        if (t < NP * 129) begin
          p = t / 129; o = t % 129;
          if (o < 64) begin
            e_en = 1; e_w = 1; e_add = 6'(o); e_wd = pat(p, o);
          end else if (o < 128) begin
            e_en = 1; e_r = 1; e_add = 6'(o - 64);
          end
        end
        calc(t, ce, cfa);
        e_err = 7'(ce); e_fa = 6'(cfa); e_pass = e_done && (ce == 0);
      end
      chk("cyc_en", bus.en, e_en);
      chk("cyc_w", bus.w, e_w);
      chk("cyc_r", bus.r, e_r);
      chk("cyc_add", bus.add, e_add);
      chk("cyc_wdata", bus.wdata, e_wd);
      chk("cyc_busy", bus.busy, e_busy);
      chk("cyc_done", bus.done, e_done);
      chk("cyc_err_cnt", bus.err_cnt, e_err);
      chk("cyc_fail_addr", bus.fail_addr, e_fa);
      chk("cyc_pass", bus.pass, e_pass);
    end
  end

  task automatic clear_faults();
    for (int k = 0; k < 64; k++) begin
      sa0[k] = 16'h0; sa1[k] = 16'h0;
    end
    zero_mode = 1'b0;
  endtask

  task automatic run_test(input string nm, input int rep_at, input int exp_err,
                          input int exp_fa, input bit exp_pass);
    int lat;
    bit got;
    got = 0; lat = 0;
    @(posedge clk); #2 bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk); #1;
      if (i == 2) chk({nm, "_wdata_a2"}, bus.wdata, 32'h0BD2);
`ifdef RAM_BIST_INV_PASS_EN
      if (i == 131) chk({nm, "_wdata_inv_a2"}, bus.wdata, 32'hF42D);
`endif
      if (i == rep_at)     bus.start = 1'b1;
      if (i == rep_at + 1) bus.start = 1'b0;
      if (bus.done) begin
        got = 1; lat = i; break;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL %s_timeout: got no done expected done at %0d", nm, LAT);
    end else begin
      chk({nm, "_latency"}, lat, LAT);
      chk({nm, "_pass"}, bus.pass, exp_pass);
      chk({nm, "_err_cnt"}, bus.err_cnt, exp_err);
      chk({nm, "_fail_addr"}, bus.fail_addr, exp_fa);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic count_dones(input string nm, input int cycles, input int exp_n);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done) n++;
    end
    chk(nm, n, exp_n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, fa, nf, a;
    bus.start = 1'b0;
    clear_faults();
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_en", bus.en, 0);
    chk("reset_err_cnt", bus.err_cnt, 0);
    chk("reset_pass", bus.pass, 0);

    run_test("good", 0, 0, 0, 1'b1);

    sa1[10] = 16'h0001;
    run_test("sa1_a10", 0, 1, 10, 1'b0);
    clear_faults();

    sa0[5] = 16'h0001; sa1[40] = 16'h0001;
    run_test("sa_a5_a40", 0, 2, 5, 1'b0);
    clear_faults();

    // Abort mid-read at address 20
    @(posedge clk); #2 bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 300; i++) begin
        @(posedge clk); #1;
        if (bus.r && bus.add == 6'd20) begin
          found = 1; break;
        end
      end
      if (!found) begin
        n_chk++;
        $display("FAIL abort_wait: got no read at 20 expected read at 20");
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_add", bus.add, 0);
    chk("abort_r", bus.r, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_err_cnt", bus.err_cnt, 0);
    rst = 1'b0;
    count_dones("abort_no_done", 150, 0);
    run_test("after_abort", 0, 0, 0, 1'b1);

    run_test("repulse", 10, 0, 0, 1'b1);
    count_dones("repulse_single_done", 140, 0);

    zero_mode = 1'b1;
    run_test("zero_rdata", 0, ZERO_ERR, 0, 1'b0);
    clear_faults();

    // start held through DONE relaunches on the following idle cycle
    @(posedge clk); #2 bus.start = 1'b1;
    begin
      bit got;
      got = 0;
      for (int i = 1; i <= 600; i++) begin
        @(posedge clk); #1;
        if (bus.done) begin
          got = 1; break;
        end
      end
      chk("held_first_done", got, 1);
    end
    @(posedge clk); #1;
    chk("held_relaunch_busy", bus.busy, 1);
    chk("held_relaunch_w", bus.w, 1);
    bus.start = 1'b0;
    count_dones("held_second_done", LAT + 5, 1);

    for (int it = 0; it < 4; it++) begin
      clear_faults();
      nf = $urandom_range(0, 4);
      for (int j = 0; j < nf; j++) begin
        a = $urandom_range(0, 63);
        if ($urandom_range(0, 1) != 0) sa1[a] = sa1[a] | 16'(1 << $urandom_range(0, 15));
        else                           sa0[a] = sa0[a] | 16'(1 << $urandom_range(0, 15));
      end
      build_bad();
      calc(DONE_T, e, fa);
      run_test("random", $urandom_range(3, 60), e, fa, e == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
